// File: rtl/pipeline_control_if.sv
// Control bundle between the stall/flush controller and the pipeline datapath:
// memory handshakes and hazard sources in, stage advance/flush strobes out.
interface pipeline_control_if;
    logic       imem_resp;
    logic       dmem_req;
    logic       dmem_resp;
    logic       branch_taken;
    logic       idex_mem_read;
    logic [2:0] idex_dest;
    logic [2:0] ifid_sr1;
    logic [2:0] ifid_sr2;
    logic       ifid_sr1_used;
    logic       ifid_sr2_used;

    logic       pc_advance;
    logic       ifid_advance;
    logic       idex_advance;
    logic       exmem_advance;
    logic       memwb_advance;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;

    modport master (
        input  imem_resp, dmem_req, dmem_resp, branch_taken, idex_mem_read,
               idex_dest, ifid_sr1, ifid_sr2, ifid_sr1_used, ifid_sr2_used,
        output pc_advance, ifid_advance, idex_advance, exmem_advance, memwb_advance,
               ifid_flush, idex_flush, exmem_flush
    );

    modport slave (
        output imem_resp, dmem_req, dmem_resp, branch_taken, idex_mem_read,
               idex_dest, ifid_sr1, ifid_sr2, ifid_sr1_used, ifid_sr2_used,
        input  pc_advance, ifid_advance, idex_advance, exmem_advance, memwb_advance,
               ifid_flush, idex_flush, exmem_flush
    );
endinterface

// File: rtl/pipeline_control.sv
// Stall/flush controller for the five-stage LC-3b pipeline, with saturating
// performance counters and a sticky memory-hang watchdog.
module pipeline_control #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    pipeline_control_if.master ctl,
    output logic [CNT_W-1:0]   stall_count,
    output logic [CNT_W-1:0]   bubble_count,
    output logic [CNT_W-1:0]   flush_count,
    output logic               mem_timeout
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             timeout_q, timeout_d;

    logic mem_stall;
    logic load_use;
    logic stall_ev;
    logic bubble_ev;
    logic flush_ev;

    assign mem_stall = !ctl.imem_resp || (ctl.dmem_req && !ctl.dmem_resp);
    assign load_use  = ctl.idex_mem_read &&
                       ((ctl.ifid_sr1_used && (ctl.ifid_sr1 == ctl.idex_dest)) ||
                        (ctl.ifid_sr2_used && (ctl.ifid_sr2 == ctl.idex_dest)));

    // Cause decode: every flush is paired with its stage advance.
    always_comb begin
        state_d           = state_q;
        ctl.pc_advance    = 1'b0;
        ctl.ifid_advance  = 1'b0;
        ctl.idex_advance  = 1'b0;
        ctl.exmem_advance = 1'b0;
        ctl.memwb_advance = 1'b0;
        ctl.ifid_flush    = 1'b0;
        ctl.idex_flush    = 1'b0;
        ctl.exmem_flush   = 1'b0;
        stall_ev          = 1'b0;
        bubble_ev         = 1'b0;
        flush_ev          = 1'b0;

        if (!reset) begin
            case (state_q)
                StInit: begin
                    ctl.ifid_advance  = 1'b1;
                    ctl.idex_advance  = 1'b1;
                    ctl.exmem_advance = 1'b1;
                    ctl.memwb_advance = 1'b1;
                    ctl.ifid_flush    = 1'b1;
                    ctl.idex_flush    = 1'b1;
                    ctl.exmem_flush   = 1'b1;
                    state_d           = StRun;
                end
                StRun: begin
                    if (mem_stall) begin
                        stall_ev = 1'b1;
                    end else if (ctl.branch_taken) begin
                        ctl.pc_advance    = 1'b1;
                        ctl.ifid_advance  = 1'b1;
                        ctl.idex_advance  = 1'b1;
                        ctl.exmem_advance = 1'b1;
                        ctl.memwb_advance = 1'b1;
                        ctl.ifid_flush    = 1'b1;
                        ctl.idex_flush    = 1'b1;
                        ctl.exmem_flush   = 1'b1;
                        flush_ev          = 1'b1;
                    end else if (load_use) begin
                        ctl.idex_advance  = 1'b1;
                        ctl.idex_flush    = 1'b1;
                        ctl.exmem_advance = 1'b1;
                        ctl.memwb_advance = 1'b1;
                        bubble_ev         = 1'b1;
                    end else begin
                        ctl.pc_advance    = 1'b1;
                        ctl.ifid_advance  = 1'b1;
                        ctl.idex_advance  = 1'b1;
                        ctl.exmem_advance = 1'b1;
                        ctl.memwb_advance = 1'b1;
                    end
                end
                default: state_d = StInit;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        wd_d         = '0;
        timeout_d    = timeout_q;

        if (stall_ev && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (bubble_ev && bubble_cnt_q != CNT_MAX) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        if (flush_ev && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_W'(1);

        // Watchdog parks at TIMEOUT-1; the stall that would reach TIMEOUT sets the flag.
        if (stall_ev) begin
            wd_d = (wd_q == WD_LAST) ? wd_q : wd_q + WD_W'(1);
            if (wd_q == WD_LAST) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StInit;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
            wd_q         <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
        end
    end

    assign stall_count  = stall_cnt_q;
    assign bubble_count = bubble_cnt_q;
    assign flush_count  = flush_cnt_q;
    assign mem_timeout  = timeout_q;

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Central stall/flush controller for the five-stage LC-3b pipeline. It drives the `advance` and `flush` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC load enable. Its decisions come from three sources: memory handshakes, load-use hazard detection, and taken-branch resolution in MEM. It also keeps saturating performance counters and a memory-hang watchdog.

## Interface
Parameters:
- `TIMEOUT`, default 255: consecutive memory-stall cycles after which `mem_timeout` sets.
- `CNT_W`, default 16: width of each performance counter.

Ports:
- `clk`  in  1  rising-edge clock. This block has one clock.
- `reset`  in  1  synchronous reset, active-high.
- `imem_resp`  in  1  instruction memory done this cycle. Fetch is requested every cycle.
- `dmem_req`  in  1  the EX/MEM instruction is a load/store.
- `dmem_resp`  in  1  data memory done this cycle.
- `branch_taken`  in  1  redirect resolved for the EX/MEM instruction.
- `idex_mem_read`  in  1  the ID/EX instruction is a load.
- `idex_dest`  in  lc3b_reg  destination of the ID/EX instruction.
- `ifid_sr1`, `ifid_sr2`  in  lc3b_reg  sources of the IF/ID instruction.
- `ifid_sr1_used`, `ifid_sr2_used`  in  1  source valid flags.
- `pc_advance`  out  1  PC load enable.
- `ifid_advance`  out  1  IF/ID register advance.
- `idex_advance`  out  1  ID/EX register advance.
- `exmem_advance`  out  1  EX/MEM register advance.
- `memwb_advance`  out  1  MEM/WB register advance.
- `ifid_flush`  out  1  IF/ID flush.
- `idex_flush`  out  1  ID/EX flush.
- `exmem_flush`  out  1  EX/MEM flush.
- `stall_count`  out  CNT_W  memory-stall cycles, saturating.
- `bubble_count`  out  CNT_W  load-use bubbles, saturating.
- `flush_count`  out  CNT_W  taken-branch flushes, saturating.
- `mem_timeout`  out  1  sticky watchdog error.

## Operation
- FSM states: INIT, RUN. The state is registered.
- While `reset`=1, all advance and flush outputs are 0. At the clock edge with `reset`=1: state←INIT, counters←0, `mem_timeout`←0, internal watchdog counter←0.
- INIT lasts exactly one cycle:
  - all four stage advances=1, all three flushes=1, `pc_advance`=0 (PC keeps its reset vector).
  - Next state is RUN.
  - Memory inputs are ignored in INIT.
- RUN: the cause is evaluated combinationally each cycle, in priority order.
  1. **mem_stall** = `!imem_resp` | (`dmem_req` & `!dmem_resp`).
     - All advances=0, all flushes=0 (global freeze).
     - `stall_count`+1.
  2. **branch** = `branch_taken`.
     - All advances=1.
     - `ifid_flush`=`idex_flush`=`exmem_flush`=1, squashing the three younger instructions.
     - `flush_count`+1.
  3. **load_use** = `idex_mem_read` & `idex_dest`≠0-agnostic match: (`ifid_sr1_used` & `ifid_sr1`==`idex_dest`) | (`ifid_sr2_used` & `ifid_sr2`==`idex_dest`).
     - `pc_advance`=`ifid_advance`=0.
     - `idex_advance`=1 with `idex_flush`=1 (bubble).
     - `exmem_advance`=`memwb_advance`=1.
     - `bubble_count`+1.
  4. **none**: all advances=1, all flushes=0.
- Any flush output is asserted only together with the matching advance=1. The flush never fires while that register is frozen.
- Branch beats load-use: the stalled IF/ID instruction is squashed anyway.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Watchdog:
  - The internal counter increments on each mem_stall cycle and clears on any non-stall cycle.
  - When it reaches TIMEOUT, `mem_timeout`←1. It stays set until `reset`.
  - The watchdog does not alter the freeze behaviour.

## Timing
- All advance/flush outputs are combinational from the current inputs and state. There is zero-cycle latency to the stage registers, which sample on the same rising edge.
- Counters, state and `mem_timeout` update on the rising edge. Their values are visible the cycle after the causing event.
- `branch_taken` arriving during a memory stall is not latched. The EX/MEM register is frozen, so the input persists, and the branch acts in the first non-stall cycle.
- A load-use condition persisting across a memory stall produces exactly one bubble, issued after the stall clears.
- After one bubble, the load has left ID/EX, so load-use deasserts. Back-to-back bubbles for the same pair never occur.
- `reset` mid-stall or mid-flush takes effect at the next edge. INIT then follows the cycle after `reset` falls.

## Test plan
- **Reset and INIT.**
  - Hold `reset` 2 cycles, then release.
  - Expect: during reset all outputs 0 and counters 0. In the next cycle, four advances=1, three flushes=1, `pc_advance`=0. In the cycle after, normal RUN with all advances=1 and flushes=0.
- **Data memory stall.**
  - `dmem_req`=1, `dmem_resp`=0 for 3 cycles, then 1.
  - Expect: all advances 0 for 3 cycles, then 1. `stall_count`=3.
- **Load-use.**
  - `idex_mem_read`=1, `idex_dest`=3, `ifid_sr2`=3, `ifid_sr2_used`=1.
  - Expect: pc/ifid advance 0, idex advance+flush 1. `bubble_count`=1. Repeat with `ifid_sr2_used`=0 and expect no bubble.
- **Branch with simultaneous load-use.**
  - Expect: all advances 1, all three flushes 1, `flush_count`=1, `bubble_count` unchanged.
- **Branch during stall.**
  - `branch_taken`=1 while `imem_resp`=0 for 2 cycles.
  - Expect: freeze for 2 cycles, then flush in cycle 3. `stall_count`=2, `flush_count`=1.
- **Watchdog.**
  - With TIMEOUT=4: `imem_resp`=0 for 4 cycles. Expect `mem_timeout`=1 after the 4th edge, and it stays 1 after `imem_resp`=1. Only `reset` clears it.
  - With `CNT_W`=2: run 5 stall cycles and expect `stall_count`=3.
